window_5x5: RTL

- Streaming 5x5 neighbourhood generator that sits directly upstream of the 5x5 Gaussian filter stage.
- Accepts one 8-bit pixel per valid cycle in raster order.
- Buffers the previous four image lines.
- Presents the full 25-pixel window, plus a qualifying valid, whenever a complete in-image 5x5 neighbourhood exists, so the combinational filter can consume it directly.

---
 rtl/window_5x5_pkg.sv | 13 +
 rtl/window_5x5_line_buffer.sv | 26 ++
 rtl/window_5x5.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/window_5x5_pkg.sv
// Shared constants and tap ordering for the 5x5 window generator and its downstream filter.
package window_5x5_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int KSIZE      = 5;
    localparam int NUM_LB     = KSIZE - 1;

    // Flattened tap index: row 0 is the oldest line, column 0 the oldest pixel.
    function automatic int tap_idx(input int r, input int c);
        return r * KSIZE + c;
    endfunction

endpackage

// File: rtl/window_5x5_line_buffer.sv
// One image line of storage: combinational read, synchronous write, so a read
// and a write at the same address in one cycle return the old contents.
module line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 8,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    assign rdata = mem_q[addr];

    // Storage write port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_5x5.sv
// Streaming 5x5 neighbourhood generator: four cascaded line buffers feed a 5x5
// shift register; a window is qualified once col>=4 and row>=4.
module window_5x5
    import window_5x5_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [DATA_W-1:0]         in_pixel,
    output logic [25*DATA_W-1:0]      win,
    output logic                      out_valid,
    output logic [15:0]               out_x,
    output logic [15:0]               out_y,
    output logic                      frame_done
);

    localparam int          AW       = $clog2(IMG_WIDTH);
    localparam logic [15:0] COL_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(IMG_HEIGHT - 1);

    logic [15:0]       col_q, col_d, row_q, row_d;
    logic [15:0]       cur_col, cur_row;
    logic [DATA_W-1:0] lb_rdata [NUM_LB];
    logic [DATA_W-1:0] lb_wdata [NUM_LB];
    logic [DATA_W-1:0] sr_q [KSIZE][KSIZE];
    logic [DATA_W-1:0] sr_d [KSIZE][KSIZE];
    logic              out_valid_q, out_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       out_x_q, out_x_d, out_y_q, out_y_d;

    // Position of the incoming pixel and the counters for the next one.
    always_comb begin
        if (in_valid && in_sof) begin
            cur_col = 16'd0;
            cur_row = 16'd0;
        end else begin
            cur_col = col_q;
            cur_row = row_q;
        end
        col_d = col_q;
        row_d = row_q;
        if (in_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = 16'd0;
                row_d = (cur_row == ROW_LAST) ? 16'd0 : cur_row + 16'd1;
            end else begin
                col_d = cur_col + 16'd1;
                row_d = cur_row;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    assign lb_wdata[0] = in_pixel;

    for (genvar n = 0; n < NUM_LB; n++) begin : g_lb
        if (n > 0) begin : g_cascade
            assign lb_wdata[n] = lb_rdata[n-1];
        end
        line_buffer #(
            .DEPTH  (IMG_WIDTH),
            .DATA_W (DATA_W),
            .AW     (AW)
        ) u_lb (
            .clk   (clk),
            .we    (in_valid),
            .addr  (cur_col[AW-1:0]),
            .wdata (lb_wdata[n]),
            .rdata (lb_rdata[n])
        );
    end

    // Shift every row left on an accepted pixel; the oldest line enters row 0.
    always_comb begin
        sr_d = sr_q;
        if (in_valid) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    sr_d[r][c] = sr_q[r][c+1];
                end
            end
            for (int r = 0; r < NUM_LB; r++) begin
                sr_d[r][KSIZE-1] = lb_rdata[NUM_LB-1-r];
            end
            sr_d[KSIZE-1][KSIZE-1] = in_pixel;
        end else begin
            sr_d = sr_q;
        end
    end

    // Window qualification and centre coordinates for the pixel just accepted.
    always_comb begin
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        if (in_valid && (cur_col >= 16'd4) && (cur_row >= 16'd4)) begin
            out_valid_d  = 1'b1;
            frame_done_d = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
            out_x_d      = cur_col - 16'd2;
            out_y_d      = cur_row - 16'd2;
        end else begin
            out_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // State registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= 16'd0;
            row_q        <= 16'd0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_x_q      <= 16'd0;
            out_y_q      <= 16'd0;
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    sr_q[r][c] <= {DATA_W{1'b0}};
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            sr_q         <= sr_d;
        end
    end

    for (genvar r = 0; r < KSIZE; r++) begin : g_row
        for (genvar c = 0; c < KSIZE; c++) begin : g_col
            assign win[tap_idx(r, c)*DATA_W +: DATA_W] = sr_q[r][c];
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;

endmodule
